// File: rtl/shift_sequencer_pkg.sv
// Shared control encodings for the shift sequencer: shift operation codes,
// FSM state constants and a small decode helper.
package shift_sequencer_pkg;

    // Shift operation codes carried on shType
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_RSV = 2'b11;

    // Sequencer FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Reserved operation returns the operand unchanged, so it needs no shifting
    function automatic logic is_passthrough(input logic [1:0] sh_type);
        return (sh_type == SH_RSV);
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational one-bit shifter: computes a single sll/srl/sra step.
module shift_step #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        sh_type,
    output logic [DATA_W-1:0] data_out
);
    import shift_sequencer_pkg::*;

    // Select the one-bit shift by operation code; reserved passes through
    always_comb begin
        data_out = data_in;
        case (sh_type)
            SH_SLL:  data_out = {data_in[DATA_W-2:0], 1'b0};
            SH_SRL:  data_out = {1'b0, data_in[DATA_W-1:1]};
            SH_SRA:  data_out = {data_in[DATA_W-1], data_in[DATA_W-1:1]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: latches an operand on start, shifts it one
// bit per cycle for shamt cycles, then pulses done for one cycle.
module shift_sequencer #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         shType,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  dataOut
);
    import shift_sequencer_pkg::*;

    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  work_q,  work_d;
    logic [1:0]         type_q,  type_d;
    logic [SHAMT_W-1:0] cnt_q,   cnt_d;
    logic [DATA_W-1:0]  step_out;

    shift_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .data_in  (work_q),
        .sh_type  (type_q),
        .data_out (step_out)
    );

    // Next-state, working register and counter update
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = dataIn;
                    type_d = shType;
                    cnt_d  = shamt;
                    if ((shamt == '0) || is_passthrough(shType)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_out;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            type_q  <= SH_SLL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign dataOut = work_q;

endmodule
